// File: rtl/softex_pkg.sv
// Shared slot types, opcodes and FP constants for the softex slot register file.
package softex_pkg;

  localparam int SLOT_ADDR_BITS = 8;

  // Most negative value of the 16-bit input format, used to seed a running maximum.
  localparam logic [15:0] FPFORMAT_IN_NEG_INF = 16'hFF80;

  typedef struct packed {
    logic [15:0] maximum;
    logic [31:0] denominator;
    logic        valid;
  } slot_t;

  typedef enum logic {
    SLOT_REQ_ALLOC = 1'b0,
    SLOT_REQ_LOAD  = 1'b1
  } slot_req_op_e;

  typedef struct packed {
    slot_req_op_e              op;
    logic [SLOT_ADDR_BITS-1:0] addr;
  } slot_req_op_t;

  typedef enum logic {
    SLOT_UPD_UPDATE = 1'b0,
    SLOT_UPD_FREE   = 1'b1
  } slot_update_op_e;

  typedef struct packed {
    slot_update_op_e           op;
    logic [SLOT_ADDR_BITS-1:0] addr;
    logic [15:0]               maximum;
    logic [31:0]               denominator;
  } slot_update_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } resp_state_e;

endpackage

// File: rtl/softex_slot_regfile_if.sv
// Request/response handshake, update port and occupancy status of the slot register file.
interface softex_slot_regfile_if
  import softex_pkg::*;
#(
  parameter int N_SLOTS        = 16,
  parameter int SLOT_ADDR_BITS = softex_pkg::SLOT_ADDR_BITS
);
  logic                         req_valid_i;
  logic                         req_ready_o;
  slot_req_op_t                 req_op_i;
  logic                         resp_valid_o;
  logic                         resp_ready_i;
  logic [SLOT_ADDR_BITS-1:0]    resp_addr_o;
  slot_t                        resp_slot_o;
  logic                         resp_err_o;
  logic                         update_valid_i;
  slot_update_op_t              update_op_i;
  logic                         update_err_o;
  logic                         full_o;
  logic [$clog2(N_SLOTS+1)-1:0] n_free_o;

  modport slave (
    input  req_valid_i, req_op_i, resp_ready_i, update_valid_i, update_op_i,
    output req_ready_o, resp_valid_o, resp_addr_o, resp_slot_o, resp_err_o,
           update_err_o, full_o, n_free_o
  );

  modport master (
    output req_valid_i, req_op_i, resp_ready_i, update_valid_i, update_op_i,
    input  req_ready_o, resp_valid_o, resp_addr_o, resp_slot_o, resp_err_o,
           update_err_o, full_o, n_free_o
  );
endinterface

// File: rtl/softex_slot_regfile_lzc.sv
// Lowest-set-bit finder over a free-slot mask; purely combinational, no backpressure.
module softex_slot_regfile_lzc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_empty
);
  always_comb begin
    o_cnt = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_cnt = CNT_W'(i);
    end
  end

  assign o_empty = ~|i_vec;
endmodule

// File: rtl/softex_slot_regfile.sv
// Slot table with ALLOC/LOAD requests (1-cycle response, held until resp_ready_i) and an
// always-accepted UPDATE/FREE port; ALLOC stalls via req_ready_o while no slot is free.
module softex_slot_regfile
  import softex_pkg::*;
#(
  parameter int N_SLOTS        = 16,
  parameter int SLOT_ADDR_BITS = softex_pkg::SLOT_ADDR_BITS
) (
  input logic                  clk_i,
  input logic                  rst_i,
  input logic                  clear_i,
  softex_slot_regfile_if.slave bus
);
  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int NF_W  = $clog2(N_SLOTS + 1);

  resp_state_e               r_state, w_state_nxt;
  logic [N_SLOTS-1:0]        r_alloc;
  slot_t                     r_slot [N_SLOTS];
  logic [SLOT_ADDR_BITS-1:0] r_resp_addr;
  slot_t                     r_resp_slot;
  logic                      r_resp_err;
  logic                      r_upd_err;

  logic                      w_clr, w_full, w_req_fire, w_alloc_fire;
  logic                      w_upd_hit, w_upd_err, w_ld_ok;
  logic [N_SLOTS-1:0]        w_upd_sel, w_ld_sel;
  logic [IDX_W-1:0]          w_free_idx;
  logic [NF_W-1:0]           w_n_free;
  slot_t                     w_ld_slot, w_resp_slot;
  logic [SLOT_ADDR_BITS-1:0] w_resp_addr;
  logic                      w_resp_err;

  assign w_clr = rst_i | clear_i;

  softex_slot_regfile_lzc #(.WIDTH(N_SLOTS), .CNT_W(IDX_W)) u_lzc (
    .i_vec   (~r_alloc),
    .o_cnt   (w_free_idx),
    .o_empty (w_full)
  );

  always_comb begin
    w_upd_sel = '0;
    w_ld_sel  = '0;
    w_n_free  = '0;
    w_ld_slot = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_upd_sel[i] = (bus.update_op_i.addr == SLOT_ADDR_BITS'(i));
      w_ld_sel[i]  = (bus.req_op_i.addr == SLOT_ADDR_BITS'(i));
      if (!r_alloc[i]) w_n_free = w_n_free + NF_W'(1);
      if (w_ld_sel[i]) w_ld_slot = r_slot[i];
    end
  end

  // Out-of-range addresses select no slot, so they fall out as unallocated.
  assign w_upd_hit = bus.update_valid_i && |(w_upd_sel & r_alloc);
  assign w_upd_err = bus.update_valid_i && !w_upd_hit;
  assign w_ld_ok   = |(w_ld_sel & r_alloc);

  assign bus.req_ready_o = ((r_state == S_IDLE) || bus.resp_ready_i) &&
                           !((bus.req_op_i.op == SLOT_REQ_ALLOC) && w_full);
  assign w_req_fire   = bus.req_valid_i && bus.req_ready_o;
  assign w_alloc_fire = w_req_fire && (bus.req_op_i.op == SLOT_REQ_ALLOC);

  always_comb begin
    w_resp_addr = bus.req_op_i.addr;
    w_resp_slot = '0;
    w_resp_err  = 1'b0;
    if (bus.req_op_i.op == SLOT_REQ_ALLOC) begin
      w_resp_addr         = SLOT_ADDR_BITS'(w_free_idx);
      w_resp_slot.maximum = FPFORMAT_IN_NEG_INF;
    end else if (!w_ld_ok) begin
      w_resp_err = 1'b1;
    end else if (w_upd_hit && (bus.update_op_i.op == SLOT_UPD_UPDATE) &&
                 (bus.update_op_i.addr == bus.req_op_i.addr)) begin
      w_resp_slot.maximum     = bus.update_op_i.maximum;
      w_resp_slot.denominator = bus.update_op_i.denominator;
      w_resp_slot.valid       = 1'b1;
    end else begin
      w_resp_slot = w_ld_slot;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_req_fire) w_state_nxt = S_RESP;
    else if ((r_state == S_RESP) && bus.resp_ready_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_state     <= S_IDLE;
      r_alloc     <= '0;
      r_resp_addr <= '0;
      r_resp_slot <= '0;
      r_resp_err  <= 1'b0;
      r_upd_err   <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) r_slot[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_upd_err <= w_upd_err;
      // An update never targets the slot being allocated: that slot is still unallocated.
      for (int i = 0; i < N_SLOTS; i++) begin
        if (w_upd_hit && w_upd_sel[i]) begin
          if (bus.update_op_i.op == SLOT_UPD_UPDATE) begin
            r_slot[i].maximum     <= bus.update_op_i.maximum;
            r_slot[i].denominator <= bus.update_op_i.denominator;
            r_slot[i].valid       <= 1'b1;
          end else begin
            r_alloc[i]       <= 1'b0;
            r_slot[i].valid  <= 1'b0;
          end
        end
        if (w_alloc_fire && (w_free_idx == IDX_W'(i))) begin
          r_alloc[i]            <= 1'b1;
          r_slot[i].maximum     <= FPFORMAT_IN_NEG_INF;
          r_slot[i].denominator <= '0;
          r_slot[i].valid       <= 1'b0;
        end
      end
      if (w_req_fire) begin
        r_resp_addr <= w_resp_addr;
        r_resp_slot <= w_resp_slot;
        r_resp_err  <= w_resp_err;
      end
    end
  end

  assign bus.resp_valid_o = (r_state == S_RESP);
  assign bus.resp_addr_o  = r_resp_addr;
  assign bus.resp_slot_o  = r_resp_slot;
  assign bus.resp_err_o   = r_resp_err;
  assign bus.update_err_o = r_upd_err;
  assign bus.full_o       = w_full;
  assign bus.n_free_o     = w_n_free;
endmodule

// File: doc/softex_slot_regfile.md
SOFTEX_SLOT_REGFILE -- requirements
Module: softex_slot_regfile

Interface
REQ-001 SHALL have parameter N_SLOTS, default 16, number of slots held; 1 <= N_SLOTS <= 2**SLOT_ADDR_BITS.
REQ-002 SHALL have parameter SLOT_ADDR_BITS, default softex_pkg::SLOT_ADDR_BITS (8), slot address width.
REQ-003 SHALL have clk_i  in  1  sole clock, all state on its rising edge.
REQ-004 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have clear_i  in  1  synchronous soft clear, same effect as rst_i.
REQ-006 SHALL have req_valid_i / req_ready_o  in/out  1  request handshake.
REQ-007 SHALL have req_op_i  in  slot_req_op_t  ALLOC or LOAD, with addr.
REQ-008 SHALL have resp_valid_o / resp_ready_i  out/in  1  response handshake.
REQ-009 SHALL have resp_addr_o  out  SLOT_ADDR_BITS  slot index served; resp_slot_o  out  slot_t  slot contents; resp_err_o  out  1  bad LOAD.
REQ-010 SHALL have update_valid_i  in  1 and update_op_i  in  slot_update_op_t  UPDATE/FREE with addr, maximum, denominator.
REQ-011 SHALL have update_err_o  out  1  one-cycle pulse on update to unallocated or out-of-range slot.
REQ-012 SHALL have full_o  out  1  no free slot; n_free_o  out  $clog2(N_SLOTS+1)  free slot count.

Function
REQ-013 Per slot state SHALL be alloc bit plus slot_t {maximum, denominator, valid}.
REQ-014 Response path SHALL be a one-entry output register, FSM IDLE/RESP; req_ready_o = (IDLE or resp_ready_i) and not (ALLOC and full_o).
REQ-015 Accepted request SHALL produce resp_valid_o on the next cycle (latency 1); response held stable until resp_ready_i.
REQ-016 ALLOC SHALL take lowest-index free slot, set alloc=1, maximum=-inf of FPFORMAT_IN (0xFF80), denominator=+0, valid=0, and return that index and contents; req addr ignored.
REQ-017 ALLOC while full_o SHALL stall (req_ready_o=0), never drop or error.
REQ-018 LOAD SHALL return slot at addr; addr >= N_SLOTS or alloc=0 SHALL return resp_err_o=1, resp_slot_o='0.
REQ-019 Update path SHALL be always-accept, single-cycle write, no ready.
REQ-020 UPDATE on allocated slot SHALL write maximum, denominator, set valid=1; FREE SHALL clear alloc and valid.
REQ-021 Update to unallocated/out-of-range addr SHALL leave state unchanged and pulse update_err_o next cycle.
REQ-022 LOAD and UPDATE to same addr in one cycle SHALL return the updated data (write-first bypass); LOAD with same-cycle FREE SHALL return pre-free data, resp_err_o=0.
REQ-023 Slot freed in cycle N SHALL NOT be allocatable before cycle N+1; ALLOC and FREE in same cycle while full SHALL stall one cycle.
REQ-024 ALLOC response SHALL reflect a same-cycle UPDATE to no other slot; the new slot is never hit by a same-cycle update (it was unallocated).
REQ-025 full_o, n_free_o SHALL be registered-state derived, reflecting allocs/frees committed by previous edge.

Reset
REQ-026 rst_i or clear_i SHALL clear all alloc/valid bits, slot data to '0, FSM to IDLE, resp_valid_o=0, resp_err_o=0, resp_addr_o=0, resp_slot_o='0, update_err_o=0, full_o=0, n_free_o=N_SLOTS.
REQ-027 Reset mid-response SHALL drop the pending response; requests in the reset cycle SHALL be discarded.

Structure
REQ-028 slot_t, slot_req_op_t, slot_update_op_t, slot_req_op_e, slot_update_op_e, SLOT_ADDR_BITS SHALL come from softex_pkg; -inf constant for FPFORMAT_IN SHALL be added there.
REQ-029 Lowest-free search SHALL be a sub-module softex_slot_lzc-equivalent; reuse common_cells lzc, no new module.

Verification
REQ-030 After reset, 16 ALLOCs back-to-back with resp_ready_i=1 -> addrs 0..15, each 0xFF80/0x0/valid=0, full_o=1 after 16th, 17th stalls.
REQ-031 UPDATE addr 3 max=0x3F80 den=0x40000000 then LOAD 3 -> resp 0x3F80/0x40000000/valid=1, err=0.
REQ-032 Same cycle LOAD 5 + UPDATE 5 max=0x4000 -> response max=0x4000.
REQ-033 Full, FREE 7 -> next cycle stalled ALLOC returns addr 7, n_free_o 1->0.
REQ-034 LOAD 20 and UPDATE 9 (unallocated) -> resp_err_o=1, update_err_o pulse, state unchanged.
REQ-035 resp_ready_i=0 for 5 cycles with pending response -> outputs stable, req_ready_o=0; rst_i mid-hold -> resp_valid_o=0 next cycle.
